fc_accum_ctrl: RTL and testbench

Sequencer for a fully-connected neuron's accumulation. It drives one shared `simple_adder` instance that sums IN_LEN streamed products and then adds a per-neuron bias. The result is presented on a valid/ready output. It sits between the multiplier array, which is the input stream, and the activation/output buffer, which is the output stream.

---
 rtl/fc_acc_pkg.sv | 14 +
 rtl/simple_adder.sv | 12 +
 rtl/fc_accum_ctrl.sv | 95 +++++++++
 tb/tb_fc_accum_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_acc_pkg.sv
// fc_acc_pkg: shared state encoding and saturation limits for fc_accum_ctrl
package fc_acc_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUT} fc_acc_state_t;

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/simple_adder.sv
// simple_adder: plain modulo-2^DATA_WIDTH adder shared by the accumulation datapath
module simple_adder #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fc_accum_ctrl.sv
// fc_accum_ctrl: sums IN_LEN streamed products plus a bias on one shared adder; FC_ACC_SAT_EN enables signed saturation
module fc_accum_ctrl
    import fc_acc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IN_LEN     = 16,
    parameter int CNT_W      = $clog2(IN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    fc_acc_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, bias_q, bias_d;
    logic [DATA_WIDTH-1:0] add_b, add_sum, add_res;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  beat;

    assign add_b = (state_q == S_BIAS) ? bias_q : in_data;

    simple_adder #(.DATA_WIDTH(DATA_WIDTH)) u_add (
        .a   (acc_q),
        .b   (add_b),
        .sum (add_sum)
    );

`ifdef FC_ACC_SAT_EN
    localparam int MSB = DATA_WIDTH - 1;
    logic ovf;
    assign ovf     = (acc_q[MSB] == add_b[MSB]) && (add_sum[MSB] != acc_q[MSB]);
    assign add_res = !ovf        ? add_sum :
                     acc_q[MSB]  ? DATA_WIDTH'(sat_min(DATA_WIDTH)) :
                                   DATA_WIDTH'(sat_max(DATA_WIDTH));
`else
    assign add_res = add_sum;
`endif

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = acc_q;
    assign busy      = (state_q != S_IDLE);
    assign beat      = in_ready && in_valid;

    // next-state and datapath updates for the idle/accumulate/bias/output sequence
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        case (state_q)
            S_IDLE: if (start) begin
                acc_d   = '0;
                cnt_d   = '0;
                bias_d  = bias;
                state_d = S_ACCUM;
            end
            S_ACCUM: if (beat) begin
                acc_d = add_res;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_LEN - 1)) state_d = S_BIAS;
            end
            S_BIAS: begin
                acc_d   = add_res;
                state_d = S_OUT;
            end
            S_OUT: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously so a partial sum is dropped at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
        end
    end

endmodule

// File: tb/tb_fc_accum_ctrl.sv
// tb_fc_accum_ctrl: scoreboard bench for fc_accum_ctrl with IN_LEN=4 and IN_LEN=1 instances
module tb_fc_accum_ctrl;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0, in_valid = 0, out_ready = 1;
    logic        start1 = 0, in_valid1 = 0, out_ready1 = 1;
    logic [15:0] bias = 0, in_data = 0;
    logic        in_ready4, out_valid4, busy4;
    logic        in_ready1, out_valid1, busy1;
    logic [15:0] out_data4, out_data1;
    logic [15:0] q4[$];
    logic [15:0] q1[$];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    fc_accum_ctrl #(.DATA_WIDTH(16), .IN_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .busy(busy4)
    );

    fc_accum_ctrl #(.DATA_WIDTH(16), .IN_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bias(bias), .in_data(in_data),
        .in_valid(in_valid1), .in_ready(in_ready1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int addm(input int a, input logic [15:0] x);
`ifdef FC_ACC_SAT_EN
        int s;
        s = a + int'($signed(x));
        return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
`else
        return (a + int'(x)) & 32'hFFFF;
`endif
    endfunction

    function automatic logic [15:0] model(input logic [15:0] b, input logic [15:0] d[$]);
        int acc;
        acc = 0;
        foreach (d[k]) acc = addm(acc, d[k]);
        return 16'(addm(acc, b));
    endfunction

    // scoreboard monitors: compare each completed output handshake with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready) begin
            if (q4.size() == 0) chk("unexpected_out4", q4.size(), 1);
            else chk("out_data4", out_data4, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) chk("unexpected_out1", q1.size(), 1);
            else chk("out_data1", out_data1, q1.pop_front());
        end
    end

    task automatic run4(input logic [15:0] b, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3, input bit stall, output int lat);
        logic [15:0] d[$];
        int i, c;
        d = {d0, d1, d2, d3};
        q4.push_back(model(b, d));
        i = 0;
        start = 1;
        bias = b;
        in_valid = 0;
        @(posedge clk); #1;
        start = 0;
        c = 1;
        while (!out_valid4 && c < 100) begin
            in_valid = (i < 4) && (!stall || (c % 2 == 1));
            in_data = (i < 4) ? d[i] : 16'($urandom);
            if (in_valid && in_ready4) i++;
            @(posedge clk); #1;
            c++;
        end
        in_valid = 0;
        lat = c;
        chk("out_valid_reached", out_valid4, 1);
    endtask

    initial begin
        int lat, c, r;
        logic [15:0] held;
        logic [15:0] d1q[$];
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready4, 0);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_out_data", out_data4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_busy1", busy1, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        run4(16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 0, lat);
        chk("latency_nostall", lat, 6);
        chk("busy_in_out", busy4, 1);
        @(posedge clk); #1;
        chk("busy_fall", busy4, 0);

        run4(16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 1, lat);
        chk("latency_stall", lat, 9);
        @(posedge clk); #1;

        out_ready = 0;
        run4(16'd5, 16'd10, 16'd20, 16'd30, 16'd40, 0, lat);
        held = out_data4;
        for (int k = 0; k < 5; k++) begin
            start = 1;
            bias = 16'($urandom);
            in_valid = 1;
            in_data = 16'($urandom);
            @(negedge clk);
            chk("bp_out_valid", out_valid4, 1);
            chk("bp_out_data", out_data4, held);
            @(posedge clk); #1;
        end
        start = 1;
        out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        in_valid = 0;
        chk("stray_start_busy", busy4, 0);
        chk("stray_start_in_ready", in_ready4, 0);

        run4(16'd0, 16'h7FFF, 16'h0002, 16'h0000, 16'h0000, 0, lat);
        @(posedge clk); #1;

        start = 1;
        bias = 16'd9;
        @(posedge clk); #1;
        start = 0;
        in_valid = 1;
        in_data = 16'd1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_in_ready", in_ready4, 0);
        chk("midrst_out_valid", out_valid4, 0);
        chk("midrst_out_data", out_data4, 0);
        chk("midrst_busy", busy4, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        run4(16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 0, lat);
        chk("latency_after_rst", lat, 6);
        @(posedge clk); #1;

        d1q = {16'd7};
        q1.push_back(model(16'hFFFE, d1q));
        start1 = 1;
        bias = 16'hFFFE;
        @(posedge clk); #1;
        start1 = 0;
        in_valid1 = 1;
        in_data = 16'd7;
        c = 1;
        while (!out_valid1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        in_valid1 = 0;
        chk("len1_latency", c, 3);
        @(posedge clk); #1;
        chk("len1_busy_fall", busy1, 0);

        for (int n = 0; n < 10; n++) begin
            out_ready = 0;
            run4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom), lat);
            r = $urandom_range(0, 3);
            repeat (r) begin @(posedge clk); #1; end
            out_ready = 1;
            @(posedge clk); #1;
            chk("rand_busy_fall", busy4, 0);
        end

        @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
